// File: rtl/axi4_burst_mem_slave.sv
// AXI4 responder backed by a word array: FIXED/INCR bursts, programmable read/write latency.
// A beat moves on a rising edge where valid and ready are both high; a source holding valid keeps its payload stable.
module axi4_burst_mem_slave #(
    parameter int          ID_WIDTH    = 4,
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          RD_LAT      = 2,
    parameter int          WR_LAT      = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                awvalid_i,
    output logic                awready_o,
    input  logic [31:0]         awaddr_i,
    input  logic [ID_WIDTH-1:0] awid_i,
    input  logic [7:0]          awlen_i,
    input  logic [2:0]          awsize_i,
    input  logic [1:0]          awburst_i,
    input  logic                wvalid_i,
    output logic                wready_o,
    input  logic [31:0]         wdata_i,
    input  logic [3:0]          wstrb_i,
    input  logic                wlast_i,
    output logic                bvalid_o,
    input  logic                bready_i,
    output logic [1:0]          bresp_o,
    output logic [ID_WIDTH-1:0] bid_o,
    input  logic                arvalid_i,
    output logic                arready_o,
    input  logic [31:0]         araddr_i,
    input  logic [ID_WIDTH-1:0] arid_i,
    input  logic [7:0]          arlen_i,
    input  logic [2:0]          arsize_i,
    input  logic [1:0]          arburst_i,
    output logic                rvalid_o,
    input  logic                rready_i,
    output logic [31:0]         rdata_o,
    output logic [1:0]          rresp_o,
    output logic                rlast_o,
    output logic [ID_WIDTH-1:0] rid_o,
    output logic [1:0]          rd_state_o,
    output logic [1:0]          wr_state_o
);
    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS) << 2;
    localparam logic [7:0]  RD_LAT_C = 8'(RD_LAT);
    localparam logic [7:0]  WR_LAT_C = 8'(WR_LAT);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_e;

    // Out-of-range outranks a bad burst/size so the worst code always wins.
    function automatic logic [1:0] beat_resp(input logic [31:0] addr, input logic [2:0] size,
                                             input logic [1:0] burst);
        if ((addr - BASE_ADDR) >= SPAN) return 2'b11;
        if (burst == 2'b10 || size > 3'd2) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst);
        return (burst == 2'b01) ? addr + (32'd1 << size) : addr;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [31:0] mem_q [DEPTH_WORDS];

    r_state_e            r_state_q, r_state_d;
    logic [31:0]         r_addr_q, r_addr_d;
    logic [ID_WIDTH-1:0] r_id_q, r_id_d;
    logic [7:0]          r_len_q, r_len_d, r_beat_q, r_beat_d, r_cnt_q, r_cnt_d;
    logic [2:0]          r_size_q, r_size_d;
    logic [1:0]          r_burst_q, r_burst_d, r_resp;

    w_state_e            w_state_q, w_state_d;
    logic [31:0]         w_addr_q, w_addr_d;
    logic [ID_WIDTH-1:0] w_id_q, w_id_d;
    logic [7:0]          w_len_q, w_len_d, w_beat_q, w_beat_d, w_cnt_q, w_cnt_d;
    logic [2:0]          w_size_q, w_size_d;
    logic [1:0]          w_burst_q, w_burst_d, w_bresp_q, w_bresp_d, w_resp, w_proto;
    logic                mem_we;
    logic [IDX_W-1:0]    w_idx;

    assign r_resp     = beat_resp(r_addr_q, r_size_q, r_burst_q);
    assign w_resp     = beat_resp(w_addr_q, w_size_q, w_burst_q);
    assign w_idx      = word_idx(w_addr_q);
    assign rid_o      = r_id_q;
    assign bid_o      = w_id_q;
    assign rd_state_o = r_state_q;
    assign wr_state_o = w_state_q;

    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_id_d    = r_id_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_beat_d  = r_beat_q;
        r_cnt_d   = r_cnt_q;
        arready_o = 1'b0;
        rvalid_o  = 1'b0;
        rdata_o   = 32'd0;
        rresp_o   = 2'b00;
        rlast_o   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                arready_o = 1'b1;
                if (arvalid_i) begin
                    r_addr_d  = araddr_i;
                    r_id_d    = arid_i;
                    r_len_d   = arlen_i;
                    r_size_d  = arsize_i;
                    r_burst_d = arburst_i;
                    r_beat_d  = 8'd0;
                    r_cnt_d   = RD_LAT_C;
                    r_state_d = (RD_LAT_C == 8'd0) ? R_DATA : R_WAIT;
                end
            end
            R_WAIT: begin
                r_cnt_d = r_cnt_q - 8'd1;
                if (r_cnt_q <= 8'd1) r_state_d = R_DATA;
            end
            R_DATA: begin
                rvalid_o = 1'b1;
                rresp_o  = r_resp;
                rlast_o  = (r_beat_q == r_len_q);
                rdata_o  = (r_resp == 2'b00) ? mem_q[word_idx(r_addr_q)] : 32'd0;
                if (rready_i) begin
                    if (rlast_o) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_beat_d = r_beat_q + 8'd1;
                        r_addr_d = next_addr(r_addr_q, r_size_q, r_burst_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_id_d    = w_id_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_beat_d  = w_beat_q;
        w_cnt_d   = w_cnt_q;
        w_bresp_d = w_bresp_q;
        awready_o = 1'b0;
        wready_o  = 1'b0;
        bvalid_o  = 1'b0;
        bresp_o   = 2'b00;
        mem_we    = 1'b0;
        // wlast must coincide exactly with the final beat of the announced length.
        w_proto   = (wlast_i != (w_beat_q == w_len_q)) ? 2'b10 : 2'b00;
        case (w_state_q)
            W_IDLE: begin
                awready_o = 1'b1;
                if (awvalid_i) begin
                    w_addr_d  = awaddr_i;
                    w_id_d    = awid_i;
                    w_len_d   = awlen_i;
                    w_size_d  = awsize_i;
                    w_burst_d = awburst_i;
                    w_beat_d  = 8'd0;
                    w_bresp_d = 2'b00;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                wready_o = 1'b1;
                if (wvalid_i) begin
                    mem_we    = (w_resp == 2'b00) && !reset;
                    w_bresp_d = worst(w_bresp_q, worst(w_resp, w_proto));
                    if (wlast_i || w_beat_q == w_len_q) begin
                        w_cnt_d   = WR_LAT_C;
                        w_state_d = (WR_LAT_C == 8'd0) ? W_RESP : W_WAIT;
                    end else begin
                        w_beat_d = w_beat_q + 8'd1;
                        w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q);
                    end
                end
            end
            W_WAIT: begin
                w_cnt_d = w_cnt_q - 8'd1;
                if (w_cnt_q <= 8'd1) w_state_d = W_RESP;
            end
            W_RESP: begin
                bvalid_o = 1'b1;
                bresp_o  = w_bresp_q;
                if (bready_i) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= 32'd0;
            r_id_q    <= '0;
            r_len_q   <= 8'd0;
            r_size_q  <= 3'd0;
            r_burst_q <= 2'b00;
            r_beat_q  <= 8'd0;
            r_cnt_q   <= 8'd0;
            w_state_q <= W_IDLE;
            w_addr_q  <= 32'd0;
            w_id_q    <= '0;
            w_len_q   <= 8'd0;
            w_size_q  <= 3'd0;
            w_burst_q <= 2'b00;
            w_beat_q  <= 8'd0;
            w_cnt_q   <= 8'd0;
            w_bresp_q <= 2'b00;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_id_q    <= r_id_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_beat_q  <= r_beat_d;
            r_cnt_q   <= r_cnt_d;
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_id_q    <= w_id_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_beat_q  <= w_beat_d;
            w_cnt_q   <= w_cnt_d;
            w_bresp_q <= w_bresp_d;
        end
    end

    // Contents survive reset; a same-cycle read sees the pre-edge value.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_i[b]) mem_q[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Directed bench for axi4_burst_mem_slave: drivers push expected R/B beats, a negedge monitor checks them.
module tb_axi4_burst_mem_slave;
    localparam int IDW = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            awvalid_i = 0, wvalid_i = 0, wlast_i = 0, bready_i = 1;
    logic            arvalid_i = 0, rready_i = 1;
    logic [31:0]     awaddr_i = 0, wdata_i = 0, araddr_i = 0;
    logic [IDW-1:0]  awid_i = 0, arid_i = 0;
    logic [7:0]      awlen_i = 0, arlen_i = 0;
    logic [2:0]      awsize_i = 0, arsize_i = 0;
    logic [1:0]      awburst_i = 0, arburst_i = 0;
    logic [3:0]      wstrb_i = 0;
    logic            awready_o, wready_o, bvalid_o, arready_o, rvalid_o, rlast_o;
    logic [1:0]      bresp_o, rresp_o, rd_state_o, wr_state_o;
    logic [IDW-1:0]  bid_o, rid_o;
    logic [31:0]     rdata_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [38:0] r_exp_q[$];   // {id, last, resp, data}
    logic [5:0]  b_exp_q[$];   // {id, resp}

    axi4_burst_mem_slave #(.ID_WIDTH(IDW)) dut (
        .clock(clock), .reset(reset),
        .awvalid_i(awvalid_i), .awready_o(awready_o), .awaddr_i(awaddr_i), .awid_i(awid_i),
        .awlen_i(awlen_i), .awsize_i(awsize_i), .awburst_i(awburst_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .wlast_i(wlast_i),
        .bvalid_o(bvalid_o), .bready_i(bready_i), .bresp_o(bresp_o), .bid_o(bid_o),
        .arvalid_i(arvalid_i), .arready_o(arready_o), .araddr_i(araddr_i), .arid_i(arid_i),
        .arlen_i(arlen_i), .arsize_i(arsize_i), .arburst_i(arburst_i),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rresp_o(rresp_o),
        .rlast_o(rlast_o), .rid_o(rid_o),
        .rd_state_o(rd_state_o), .wr_state_o(wr_state_o)
    );

    // clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    logic [38:0] r_prev;
    logic [5:0]  b_prev;
    logic        r_stall = 1'b0;
    logic        b_stall = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            r_stall = 1'b0;
            b_stall = 1'b0;
        end else begin
            if (r_stall) chk("r_stable", {rvalid_o, rid_o, rlast_o, rresp_o, rdata_o}, {1'b1, r_prev});
            if (b_stall) chk("b_stable", {bvalid_o, bid_o, bresp_o}, {1'b1, b_prev});
            if (rvalid_o && rready_i) begin
                if (r_exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL r_unexpected: got beat %0h with nothing expected", rdata_o);
                end else begin
                    chk("r_beat", {rid_o, rlast_o, rresp_o, rdata_o}, r_exp_q.pop_front());
                end
            end
            if (bvalid_o && bready_i) begin
                if (b_exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL b_unexpected: got bid %0h with nothing expected", bid_o);
                end else begin
                    chk("b_resp", {bid_o, bresp_o}, b_exp_q.pop_front());
                end
            end
            r_stall = rvalid_o && !rready_i;
            r_prev  = {rid_o, rlast_o, rresp_o, rdata_o};
            b_stall = bvalid_o && !bready_i;
            b_prev  = {bid_o, bresp_o};
        end
    end

    // driver tasks (all start and end just after a rising edge)
    task automatic push_r(input logic [31:0] d, input logic [1:0] resp, input logic last,
                          input logic [3:0] id);
        r_exp_q.push_back({id, last, resp, d});
    endtask

    task automatic ar_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        arvalid_i = 1; araddr_i = a; arid_i = id; arlen_i = len; arsize_i = size; arburst_i = burst;
        n = 0;
        do begin @(negedge clock); n++; end while (!arready_o && n < 50);
        if (!arready_o) begin n_cmp++; n_err++; $display("FAIL ar_timeout: arready 0 expected 1"); end
        @(posedge clock); #1;
        arvalid_i = 0;
    endtask

    task automatic aw_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        awvalid_i = 1; awaddr_i = a; awid_i = id; awlen_i = len; awsize_i = size; awburst_i = burst;
        n = 0;
        do begin @(negedge clock); n++; end while (!awready_o && n < 50);
        if (!awready_o) begin n_cmp++; n_err++; $display("FAIL aw_timeout: awready 0 expected 1"); end
        @(posedge clock); #1;
        awvalid_i = 0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        int n;
        wvalid_i = 1; wdata_i = d; wstrb_i = s; wlast_i = l;
        n = 0;
        do begin @(negedge clock); n++; end while (!wready_o && n < 50);
        if (!wready_o) begin n_cmp++; n_err++; $display("FAIL w_timeout: wready 0 expected 1"); end
        @(posedge clock); #1;
    endtask

    task automatic write_burst(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                               input logic [31:0] base, input logic [3:0] strb, input int early,
                               input logic [1:0] exp_resp);
        int  n;
        logic l;
        b_exp_q.push_back({id, exp_resp});
        aw_send(a, id, len, 3'd2, 2'b01);
        for (int i = 0; i <= int'(len); i++) begin
            l = (early >= 0) ? (i == early) : (i == int'(len));
            w_beat(base + 32'(i), strb, l);
            if (early >= 0 && i == early) break;
        end
        wvalid_i = 0; wlast_i = 0;
        n = 0;
        do begin @(negedge clock); n++; end while (!bvalid_o && n < 20);
        chk("b_latency", n, 2);
    endtask

    task automatic read_burst(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input bit chk_t);
        int n, k;
        ar_send(a, id, len, size, burst);
        if (chk_t) begin
            n = 0;
            do begin @(negedge clock); n++; end while (!rvalid_o && n < 20);
            chk("r_latency", n, 3);
            k = 1;
            while (!(rvalid_o && rlast_o) && k < 40) begin @(negedge clock); k++; end
            chk("r_beat_span", k, int'(len) + 1);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((r_exp_q.size() != 0 || b_exp_q.size() != 0) && n < 300) begin
            @(negedge clock); n++;
        end
        if (r_exp_q.size() != 0 || b_exp_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: r left %0d b left %0d expected 0", r_exp_q.size(), b_exp_q.size());
            r_exp_q.delete(); b_exp_q.delete();
        end
        @(posedge clock); #1;
    endtask

    // stimulus
    initial begin
        int n;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_arready", arready_o, 1);
        chk("rst_awready", awready_o, 1);
        chk("rst_wready", wready_o, 0);
        chk("rst_bvalid", bvalid_o, 0);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_rlast", rlast_o, 0);
        chk("rst_resps", {rresp_o, bresp_o}, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_ids", {rid_o, bid_o}, 0);
        reset = 0;
        @(posedge clock); #1;

        // single read after preload
        write_burst(32'h8000_0010, 4'd1, 8'd0, 32'hDEAD_BEEF, 4'hF, -1, 2'b00);
        drain();
        push_r(32'hDEAD_BEEF, 2'b00, 1'b1, 4'd5);
        read_burst(32'h8000_0010, 4'd5, 8'd0, 3'd2, 2'b01, 1'b1);
        drain();

        // INCR burst write then read
        write_burst(32'h8000_0100, 4'd2, 8'd3, 32'd1, 4'hF, -1, 2'b00);
        drain();
        for (int i = 1; i <= 4; i++) push_r(32'(i), 2'b00, i == 4, 4'd3);
        read_burst(32'h8000_0100, 4'd3, 8'd3, 3'd2, 2'b01, 1'b1);
        drain();

        // FIXED burst repeats the same word
        for (int i = 0; i < 3; i++) push_r(32'd1, 2'b00, i == 2, 4'd4);
        read_burst(32'h8000_0100, 4'd4, 8'd2, 3'd2, 2'b00, 1'b0);
        drain();

        // partial strobe
        write_burst(32'h8000_0200, 4'd1, 8'd0, 32'hFFFF_FFFF, 4'hF, -1, 2'b00);
        write_burst(32'h8000_0200, 4'd1, 8'd0, 32'h1234_5678, 4'b0101, -1, 2'b00);
        drain();
        push_r(32'hFF34_FF78, 2'b00, 1'b1, 4'd2);
        read_burst(32'h8000_0200, 4'd2, 8'd0, 3'd2, 2'b01, 1'b0);
        drain();

        // read backpressure: rready toggles every cycle
        for (int i = 1; i <= 4; i++) push_r(32'(i), 2'b00, i == 4, 4'd6);
        ar_send(32'h8000_0100, 4'd6, 8'd3, 3'd2, 2'b01);
        n = 0;
        while (r_exp_q.size() != 0 && n < 100) begin @(posedge clock); #1; rready_i = ~rready_i; n++; end
        rready_i = 1;
        drain();

        // write response backpressure: bready low for 5 cycles
        bready_i = 0;
        b_exp_q.push_back({4'd7, 2'b00});
        aw_send(32'h8000_0300, 4'd7, 8'd1, 3'd2, 2'b01);
        w_beat(32'h0000_00AA, 4'hF, 1'b0);
        w_beat(32'h0000_00BB, 4'hF, 1'b1);
        wvalid_i = 0; wlast_i = 0;
        n = 0;
        do begin @(negedge clock); n++; end while (!bvalid_o && n < 20);
        repeat (5) @(negedge clock);
        chk("b_held", {bvalid_o, bid_o, bresp_o}, {1'b1, 4'd7, 2'b00});
        @(posedge clock); #1;
        bready_i = 1;
        drain();
        push_r(32'h0000_00AA, 2'b00, 1'b0, 4'd7);
        push_r(32'h0000_00BB, 2'b00, 1'b1, 4'd7);
        read_burst(32'h8000_0300, 4'd7, 8'd1, 3'd2, 2'b01, 1'b0);
        drain();

        // error responses
        push_r(32'd0, 2'b11, 1'b1, 4'd8);
        read_burst(32'h1000_0000, 4'd8, 8'd0, 3'd2, 2'b01, 1'b0);
        drain();
        push_r(32'd0, 2'b10, 1'b0, 4'd9);
        push_r(32'd0, 2'b10, 1'b1, 4'd9);
        read_burst(32'h8000_0000, 4'd9, 8'd1, 3'd2, 2'b10, 1'b0);
        drain();
        push_r(32'd0, 2'b10, 1'b1, 4'd10);
        read_burst(32'h8000_0010, 4'd10, 8'd0, 3'd3, 2'b01, 1'b0);
        drain();
        write_burst(32'h8000_0400, 4'd10, 8'd3, 32'h55, 4'hF, 1, 2'b10);
        drain();
        write_burst(32'h1000_0000, 4'd11, 8'd0, 32'h99, 4'hF, -1, 2'b11);
        drain();

        // last word in range, then an INCR step past the end
        write_burst(32'h8000_3FFC, 4'd12, 8'd0, 32'h77, 4'hF, -1, 2'b00);
        drain();
        push_r(32'h77, 2'b00, 1'b0, 4'd12);
        push_r(32'd0, 2'b11, 1'b1, 4'd12);
        read_burst(32'h8000_3FFC, 4'd12, 8'd1, 3'd2, 2'b01, 1'b0);
        drain();

        // same-cycle read and write of one word returns the old value
        write_burst(32'h8000_0500, 4'd1, 8'd0, 32'h1111_2222, 4'hF, -1, 2'b00);
        drain();
        push_r(32'h1111_2222, 2'b00, 1'b1, 4'd11);
        b_exp_q.push_back({4'd12, 2'b00});
        fork
            ar_send(32'h8000_0500, 4'd11, 8'd0, 3'd2, 2'b01);
            aw_send(32'h8000_0500, 4'd12, 8'd0, 3'd2, 2'b01);
        join
        n = 0;
        do begin @(negedge clock); n++; end while (!rvalid_o && n < 20);
        wvalid_i = 1; wdata_i = 32'h3333_4444; wstrb_i = 4'hF; wlast_i = 1;
        chk("conc_wready", wready_o, 1);
        @(posedge clock); #1;
        wvalid_i = 0; wlast_i = 0;
        drain();
        push_r(32'h3333_4444, 2'b00, 1'b1, 4'd13);
        read_burst(32'h8000_0500, 4'd13, 8'd0, 3'd2, 2'b01, 1'b0);
        drain();

        // reset in the middle of a read burst
        for (int i = 1; i <= 4; i++) push_r(32'(i), 2'b00, i == 4, 4'd14);
        ar_send(32'h8000_0100, 4'd14, 8'd3, 3'd2, 2'b01);
        n = 0;
        while (r_exp_q.size() > 3 && n < 40) begin @(negedge clock); n++; end
        @(posedge clock); #1;
        rready_i = 0;
        reset = 1;
        @(posedge clock); #1;
        chk("midrst_rvalid", rvalid_o, 0);
        chk("midrst_arready", arready_o, 1);
        chk("midrst_rlast", rlast_o, 0);
        reset = 0;
        r_exp_q.delete();
        rready_i = 1;
        @(posedge clock); #1;
        push_r(32'hDEAD_BEEF, 2'b00, 1'b1, 4'd15);
        read_burst(32'h8000_0010, 4'd15, 8'd0, 3'd2, 2'b01, 1'b1);
        drain();

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi4_burst_mem_slave.md
Name: axi4_burst_mem_slave

Overview:
- AXI4 responder (slave) memory model that answers the CPU master port's AR/R and AW/W/B channels.
- Backs a word-addressed register array and supports FIXED and INCR bursts.
- Read and write latency are programmable.
- Used as the on-chip memory behind the crossbar in non-SoC builds and as the target for master-port verification.

Parameters:
ID_WIDTH, 4, width of AXI ID fields
DEPTH_WORDS, 4096, number of 32-bit words in the array (power of two)
BASE_ADDR, 32'h8000_0000, byte address of word 0
RD_LAT, 2, idle cycles between AR handshake and first R beat
WR_LAT, 1, idle cycles between last W handshake and B valid

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
awvalid in 1; awready out 1; awaddr in 32; awid in ID_WIDTH; awlen in 8; awsize in 3; awburst in 2
wvalid in 1; wready out 1; wdata in 32; wstrb in 4; wlast in 1
bvalid out 1; bready in 1; bresp out 2; bid out ID_WIDTH
arvalid in 1; arready out 1; araddr in 32; arid in ID_WIDTH; arlen in 8; arsize in 3; arburst in 2
rvalid out 1; rready in 1; rdata out 32; rresp out 2; rlast out 1; rid out ID_WIDTH

Behaviour:
Reset:
- Both FSMs go to IDLE; all counters clear.
- arready=1, awready=1. wready, bvalid, rvalid, rlast = 0. rresp, bresp, rdata = 0. rid, bid = 0.
- Memory contents are not cleared.
- Reset mid-burst aborts the burst with no further beats or response.

Read FSM (R_IDLE -> R_WAIT -> R_DATA -> R_IDLE):
- R_IDLE: arready=1. On arvalid&arready, latch addr, id, len, size, burst; clear beat count. Go to R_WAIT with cnt=RD_LAT; go straight to R_DATA if RD_LAT=0.
- R_WAIT: arready=0. cnt decrements; go to R_DATA when cnt reaches 0. First rvalid is asserted exactly RD_LAT+1 cycles after the AR handshake cycle.
- R_DATA: rvalid=1.
  - rdata = mem[(addr-BASE_ADDR)>>2], combinational from the current beat address.
  - rid = latched id. rlast=1 when beat==len.
  - On rvalid&rready:
    - If rlast: return to R_IDLE; arready rises next cycle.
    - Otherwise: beat+1, and addr += (1<<size) if INCR, unchanged if FIXED.
  - Beats are back-to-back with no inter-beat latency.
  - rvalid and all R outputs are held stable while rready=0.

Write FSM (W_IDLE -> W_DATA -> W_WAIT -> W_RESP -> W_IDLE):
- W_IDLE: awready=1, wready=0. On AW handshake, latch fields and go to W_DATA.
- W_DATA: wready=1. Each W handshake writes the bytes of mem[idx] enabled by wstrb (bit i -> byte i). Address advances as in the read FSM. Leave W_DATA when wlast=1 or beat==len.
- W_WAIT: WR_LAT cycles; skipped if WR_LAT=0.
- W_RESP: bvalid=1, bid = latched id. Hold until bready; then go to W_IDLE.

Response codes (rresp/bresp):
- OKAY 2'b00.
- DECERR 2'b11: any beat address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS). rdata=0; write is dropped.
- SLVERR 2'b10: burst==WRAP, or size>2. No memory access; beat count is still honoured.
- Write responses: bresp=SLVERR if wlast arrives before beat==len, or wlast=0 at beat==len; the FSM still exits W_DATA. bresp is the worst (highest) code seen across the burst.
- rresp is per beat.

Concurrency:
- Read and write FSMs are fully independent.
- Same-cycle R beat and W beat to the same word: rdata returns the old value; the write takes effect at the clock edge.
- Addresses wrap modulo 2^32 during the address increment; an out-of-range address then yields DECERR.
- A W beat presented before its AW is not accepted (wready=0 in W_IDLE).

Test Plan:
- Single read: AR araddr=0x8000_0010, len=0 after preloading mem[4]=0xDEADBEEF -> rvalid exactly 3 cycles after the handshake; rdata=0xDEADBEEF, rresp=0, rlast=1, rid=arid.
- INCR write/read burst: AW 0x8000_0100, len=3, data 1..4, all strobes set -> bresp=0 two cycles after the last beat. AR of the same burst -> 4 back-to-back beats 1,2,3,4, with rlast on beat 4 only.
- Partial strobe: word holds 0xFFFF_FFFF; write 0x1234_5678 with wstrb=4'b0101 -> readback 0xFF34_FF78.
- Backpressure: rready toggled 0/1 every cycle, and bready held 0 for 5 cycles -> R outputs and bvalid/bid stay stable; no beat is lost or duplicated.
- Errors: araddr=0x1000_0000 -> rresp=2'b11, rdata=0. arburst=WRAP, len=1 -> two beats with rresp=2'b10. Write with early wlast on beat 1 of len=3 -> bresp=2'b10.
- Concurrency and reset: simultaneous read and write bursts to the same word -> old data returned. Reset asserted in R_DATA mid-burst -> rvalid=0 next cycle; arready=1.
